// File: rtl/iomem_arbiter_if.sv
// picorv32-style native memory handshake bundle shared by the arbiter's
// master-facing ports and its single slave-bus port.
interface iomem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for one iomem slave bus, with a per-transfer
// timeout that completes hung accesses with ERR_DATA and a sticky error flag.
module iomem_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             resetn,
  iomem_arbiter_if.slave   m0,
  iomem_arbiter_if.slave   m1,
  iomem_arbiter_if.master  s,
  input  logic             err_clr,
  output logic             err,
  output logic             err_master,
  output logic             grant,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_prio;
  logic             r_err;
  logic             r_errMaster;
  logic [CNT_W-1:0] r_cnt;

  logic        w_busy;
  logic        w_selValid;
  logic [3:0]  w_selWstrb;
  logic [31:0] w_selAddr;
  logic [31:0] w_selWdata;
  logic        w_done;
  logic        w_timeout;
  logic        w_ack;
  logic [31:0] w_rdata;

  assign w_busy     = (r_state == BUSY);
  assign w_selValid = r_grant ? m1.valid : m0.valid;
  assign w_selWstrb = r_grant ? m1.wstrb : m0.wstrb;
  assign w_selAddr  = r_grant ? m1.addr  : m0.addr;
  assign w_selWdata = r_grant ? m1.wdata : m0.wdata;

  // A slave response in the final allowed cycle beats the timeout.
  assign w_done    = w_busy & w_selValid & s.ready;
  assign w_timeout = w_busy & w_selValid & ~s.ready & (r_cnt == CNT_LAST);
  assign w_ack     = w_done | w_timeout;
  assign w_rdata   = w_done ? s.rdata : ERR_DATA;

  assign s.valid = w_busy & w_selValid;
  assign s.wstrb = w_busy ? w_selWstrb : 4'h0;
  assign s.addr  = w_busy ? w_selAddr  : 32'h0;
  assign s.wdata = w_busy ? w_selWdata : 32'h0;

  assign m0.ready = w_ack & ~r_grant;
  assign m1.ready = w_ack &  r_grant;
  assign m0.rdata = (w_ack & ~r_grant) ? w_rdata : 32'h0;
  assign m1.rdata = (w_ack &  r_grant) ? w_rdata : 32'h0;

  assign err        = r_err;
  assign err_master = r_errMaster;
  assign grant      = r_grant;
  assign busy       = w_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_prio      <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_errMaster <= 1'b0;
    end else begin
      // A timeout later in this block overrides a same-cycle clear.
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0.valid || m1.valid) begin
            r_grant <= (m0.valid && m1.valid) ? r_prio : m1.valid;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_selValid || s.ready || (r_cnt == CNT_LAST)) begin
            if (w_timeout) begin
              r_err       <= 1'b1;
              r_errMaster <= r_grant;
            end
            r_prio  <= ~r_grant;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master round-robin arbiter that shares a single iomem slave bus (valid/ready/wstrb/addr/wdata/rdata, picorv32 native memory handshake) between the SoC CPU iomem port and a second requester such as a debug/DMA engine. It sits between the iomem masters and the top-level peripheral decode (GPIO at 0x03xxxxxx and the rest). It serialises transfers, forwards the one-cycle ready pulse to the granted master, and terminates any slave access that hangs past a programmable timeout with an error response and a sticky error flag.

## Interface
- TIMEOUT, 256: max cycles a granted transfer may wait for s_ready; legal range 2..65535.
- ERR_DATA, 32'hDEADBEEF: rdata returned on a timed-out transfer.
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- m0_valid, m1_valid  in  1  master request; held until that master's ready.
- m0_ready, m1_ready  out  1  one-cycle completion pulse to the master.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_addr, m1_addr  in  32  address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_rdata, m1_rdata  out  32  read data; valid only while the matching ready is high.
- s_valid  out  1  request to the slave bus.
- s_ready  in  1  slave completion.
- s_wstrb  out  4, s_addr  out  32, s_wdata  out  32  muxed from the granted master.
- s_rdata  in  32  slave read data.
- err_clr  in  1  clears err; synchronous, one-cycle pulse.
- err  out  1  sticky, set on any timeout.
- err_master  out  1  index of the master whose transfer timed out most recently.
- grant  out  1  index of the current/last granted master.
- busy  out  1  high in state BUSY.

## Operation
- States: IDLE, BUSY. Registers: state, grant, prio (next preferred master), cnt (timeout counter, width clog2(TIMEOUT)), err, err_master.
- IDLE: s_valid=0, both ready=0. If m0_valid or m1_valid, load grant and go to BUSY. With both valid, grant=prio; with one valid, that one wins. Clear cnt.
- BUSY: s_valid = m[grant]_valid; s_addr/s_wdata/s_wstrb driven combinationally from m[grant]. In IDLE the s_* outputs are 0.
- Normal completion: in BUSY, s_ready=1 asserts m[grant]_ready and m[grant]_rdata=s_rdata in the same cycle; next state IDLE; prio = ~grant.
- Timeout: in BUSY, cnt==TIMEOUT-1 with s_ready=0 asserts m[grant]_ready with rdata=ERR_DATA, sets err, err_master=grant; next state IDLE; prio = ~grant. s_ready and timeout in the same cycle count as normal completion; no error.
- Abort: m[grant]_valid low in BUSY (protocol violation) gives no ready; return to IDLE, prio = ~grant, err unaffected.
- s_ready in IDLE is ignored (late slave response after timeout).
- Non-granted master's ready is always 0 and its rdata is 0. The granted master's rdata is 0 when its ready is low.
- err_clr clears err; a timeout in the same cycle wins (err stays 1).
- Reset (any time, including mid-transfer): state=IDLE, grant=0, prio=0, cnt=0, err=0, err_master=0. All outputs 0. An in-flight transfer is dropped without ready.

## Timing
- Arbitration latency: 1 cycle (request seen in IDLE at edge N, s_valid high from cycle N+1).
- Zero-wait slave: ready at cycle N+1, so 2 cycles per transfer; back-to-back same master gives 1 idle cycle between transfers.
- Timeout ready asserted exactly TIMEOUT cycles after entering BUSY.
- m*_ready, m*_rdata and s_* are combinational from state, grant and slave inputs. All other outputs are registered.

## Test plan
- Single read: m0 reads 0x03000000, slave ready after 2 wait cycles with rdata 0x000000A5 -> s_valid high for 3 cycles, m0_ready pulse with rdata 0x000000A5, m1 sees nothing.
- Contention: m0 and m1 valid in the same cycle after reset -> m0 served first, then m1, then m0 again on re-request; grant sequence 0,1,0, no starvation over 100 iterations.
- Write pass-through: m1 writes wstrb 4'b0011, wdata 0x12345678 -> s_wstrb/s_wdata match exactly while m1 is granted.
- Timeout: TIMEOUT=8, slave never responds -> m0_ready at the 8th BUSY cycle with rdata 0xDEADBEEF; err=1, err_master=0; a later s_ready in IDLE has no effect; err_clr pulse -> err=0.
- Edge on timeout: s_ready arrives on cycle TIMEOUT -> normal data, err stays 0.
- Reset mid-transfer: resetn low during BUSY -> s_valid and all outputs 0 immediately, no ready pulse; after release, the first request is served from IDLE with prio=0.
